// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with local byte-writable instruction memory
//
// Purpose:
//   Holds the program counter, reads one 32-bit word per cycle from a local
//   instruction memory and presents it, with its address, to the decode stage.
//   Supports downstream stall, taken-branch redirect and pipeline flush.
//
// Parameters:
//   IMEM_WORDS  instruction memory depth in 32-bit words (power of two, >= 2)
//   RESET_PC    PC value loaded on reset
//   NOP_INSTR   encoding driven on instr_o for bubbles
//
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous active-high reset
//   wdata_i      instruction memory write data
//   waddr_i      instruction memory write word index
//   wen_i        per-byte write enables (bit n writes wdata_i[8n+7:8n])
//   fetch_en_i   fetch enable (IDLE <-> RUN)
//   stall_i      downstream stall: hold PC and output register
//   br_valid_i   taken branch / jump redirect
//   br_target_i  redirect target (bits [1:0] ignored)
//   flush_i      pipeline flush: emit a bubble, PC not advanced
//   instr_o      fetched instruction
//   pc_o         address of instr_o
//   valid_o      instr_o is a real instruction rather than a bubble

module fetch_unit #(
    parameter int          IMEM_WORDS = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   wdata_i,
    input  logic [$clog2(IMEM_WORDS)-1:0] waddr_i,
    input  logic [3:0]                    wen_i,
    input  logic                          fetch_en_i,
    input  logic                          stall_i,
    input  logic                          br_valid_i,
    input  logic [31:0]                   br_target_i,
    input  logic                          flush_i,
    output logic [31:0]                   instr_o,
    output logic [31:0]                   pc_o,
    output logic                          valid_o
);

    localparam int AW = $clog2(IMEM_WORDS);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] instr_d;
    logic [31:0] pc_out_d;
    logic        valid_d;

    logic [31:0]   imem [IMEM_WORDS];
    logic [AW-1:0] pc_idx;
    logic [31:0]   fetch_word;

    // Instruction memory. Deliberately outside the reset domain: contents
    // survive reset and writes issued while rst is high still land.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wen_i[b]) begin
                imem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // Upper PC bits are ignored so fetch wraps modulo the memory size.
    // The read is sampled by the same edge that may write this word, so it
    // returns the old contents (read-before-write).
    assign pc_idx     = pc_q[AW+1:2];
    assign fetch_word = imem[pc_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_o <= NOP_INSTR;
            pc_o    <= RESET_PC;
            valid_o <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_o <= instr_d;
            pc_o    <= pc_out_d;
            valid_o <= valid_d;
        end
    end

    // Priority: redirect > flush > stall > FSM state. The FSM tracks
    // fetch_en_i on every edge; the output action uses the current state, so
    // the first real fetch comes one edge after entering RUN.
    always_comb begin
        state_d  = fetch_en_i ? RUN : IDLE;
        pc_d     = pc_q;
        instr_d  = instr_o;
        pc_out_d = pc_o;
        valid_d  = valid_o;

        if (br_valid_i) begin
            // Misaligned target bits are dropped without complaint.
            pc_d    = br_target_i & ~32'h0000_0003;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (flush_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (stall_i) begin
            // hold everything
        end else begin
            case (state_q)
                RUN: begin
                    instr_d  = fetch_word;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    pc_d     = pc_q + 32'd4;
                end
                default: begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 32: instruction memory depth in 32-bit words, power of two.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value after reset.
REQ-003 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0): bubble encoding.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port wdata_i  input  32  instruction memory write data.
REQ-007 SHALL have port waddr_i  input  $clog2(IMEM_WORDS)  memory write word index.
REQ-008 SHALL have port wen_i  input  4  per-byte write enables; bit n writes wdata_i[8n+7:8n].
REQ-009 SHALL have port fetch_en_i  input  1  fetch enable.
REQ-010 SHALL have port stall_i  input  1  downstream stall; hold PC and output register.
REQ-011 SHALL have port br_valid_i  input  1  taken-branch/jump redirect from EX.
REQ-012 SHALL have port br_target_i  input  32  redirect target address.
REQ-013 SHALL have port flush_i  input  1  pipeline flush from EX.
REQ-014 SHALL have port instr_o  output  32  fetched instruction to ID.
REQ-015 SHALL have port pc_o  output  32  address of instr_o.
REQ-016 SHALL have port valid_o  output  1  instr_o is a real instruction, not a bubble.

Function
REQ-017 SHALL hold internal PC register and two-state FSM: IDLE, RUN.
REQ-018 IDLE -> RUN when fetch_en_i=1; RUN -> IDLE when fetch_en_i=0 (takes effect same edge).
REQ-019 In IDLE: PC held; instr_o<=NOP_INSTR, valid_o<=0, pc_o held.
REQ-020 In RUN, stall_i=0, no redirect/flush: instr_o<=imem[PC index], pc_o<=PC, valid_o<=1, PC<=PC+4; latency one cycle from PC to instr_o.
REQ-021 PC index = PC[$clog2(IMEM_WORDS)+1:2]; higher bits ignored, so fetch wraps modulo memory size; PC+4 wraps modulo 2^32.
REQ-022 stall_i=1 without redirect: PC, instr_o, pc_o, valid_o all held.
REQ-023 br_valid_i=1 (any state, overrides stall_i and fetch_en_i): PC<={br_target_i[31:2],2'b00}; instr_o<=NOP_INSTR, valid_o<=0, pc_o held; first target instruction appears next cycle after.
REQ-024 flush_i=1 with br_valid_i=0: instr_o<=NOP_INSTR, valid_o<=0; PC not advanced; overrides stall_i.
REQ-025 br_valid_i and flush_i both 1: behave per REQ-023 only.
REQ-026 Memory write: on clock edge, bytes selected by wen_i updated at waddr_i, independent of FSM, stall, redirect.
REQ-027 Same-cycle read and write of same word: read returns old contents (read-before-write); new data visible next fetch.
REQ-028 Memory contents not initialised by reset; writes during reset still performed.
REQ-029 Misaligned br_target_i bits [1:0] silently dropped; no exception raised.

Reset
REQ-030 rst=1 SHALL asynchronously force: FSM=IDLE, PC=RESET_PC, instr_o=NOP_INSTR, pc_o=RESET_PC, valid_o=0.
REQ-031 Reset mid-fetch or mid-redirect SHALL discard pending redirect; first fetch after release is from RESET_PC.
REQ-032 rst deasserted with fetch_en_i=1 SHALL enter RUN at first edge; word 0 on instr_o one edge later.

Verification
REQ-033 Load words 0..4 = addi,beq,slti,ori,xori; fetch_en_i=1 -> instr_o sequence matches, pc_o 0,4,8,12,16, valid_o=1.
REQ-034 Running at PC=8, br_valid_i=1 target 0x28 -> next cycle valid_o=0, instr_o=0x00000013; following cycle pc_o=0x28, instr_o=imem[10].
REQ-035 stall_i=1 for 3 cycles at pc_o=4 -> outputs unchanged 3 cycles; then pc_o=8.
REQ-036 PC=0x7C, IMEM_WORDS=32 -> pc_o=0x7C then 0x80, instr_o=imem[31] then imem[0].
REQ-037 Write wen_i=4'b0011, wdata_i=0xAAAA5555 to word 2 holding 0x00000013 -> later fetch of 0x8 returns 0x00005555.
REQ-038 Assert rst mid-run after br_valid_i -> outputs reset immediately without clock; after release pc_o=0 first.
